// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises I-cache and D-cache line requests onto one
// physical memory port.
//
// Handshake: a cache holds its request level until it sees a one-cycle resp
// pulse. The arbiter latches the winning request in IDLE. It holds the pmem
// strobe with stable address/data until pmem_resp. It then spends exactly one
// DONE cycle pulsing resp to the granted cache. Requests seen during DONE are
// ignored, so a requester can drop its request without being re-granted.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating tie-break; the
// default is strict D-cache priority).
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_pmem_address;
  logic [LINE_W-1:0] r_pmem_wdata;
  logic [LINE_W-1:0] r_icache_rdata;
  logic [LINE_W-1:0] r_dcache_rdata;
  logic              r_icache_resp;
  logic              r_dcache_resp;

  logic w_d_req;
  logic w_i_req;
  logic w_grant_d;
  logic w_grant_i;
  logic w_take_resp;

  assign w_d_req = dcache_read | dcache_write;
  assign w_i_req = icache_read;

`ifdef ARB_ROUND_ROBIN_EN
  // r_last_d = 1 when the D-cache held the most recent grant.
  logic r_last_d;

  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

  // Track the most recent winner so that ties alternate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE && (w_d_req || w_i_req)) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = w_d_req;
`endif

  assign w_grant_i   = w_i_req & ~w_grant_d;
  assign w_take_resp = pmem_resp && (r_state == SERVE_I || r_state == SERVE_D);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: grant in IDLE, wait for pmem_resp, one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = SERVE_D;
        end else if (w_grant_i) begin
          w_state_nxt = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the granted request, capture read data, pulse resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_icache_rdata <= '0;
      r_dcache_rdata <= '0;
      r_icache_resp  <= 1'b0;
      r_dcache_resp  <= 1'b0;
    end else begin
      r_icache_resp <= 1'b0;
      r_dcache_resp <= 1'b0;
      if (r_state == IDLE && w_grant_d) begin
        // Read and write together is treated as a write-back.
        r_pmem_address <= dcache_address;
        r_pmem_wdata   <= dcache_wdata;
        r_pmem_write   <= dcache_write;
        r_pmem_read    <= ~dcache_write;
      end else if (r_state == IDLE && w_grant_i) begin
        r_pmem_address <= icache_address;
        r_pmem_write   <= 1'b0;
        r_pmem_read    <= 1'b1;
      end
      if (w_take_resp) begin
        r_pmem_read  <= 1'b0;
        r_pmem_write <= 1'b0;
        if (r_state == SERVE_I) begin
          r_icache_rdata <= pmem_rdata;
          r_icache_resp  <= 1'b1;
        end else begin
          if (!r_pmem_write) begin
            r_dcache_rdata <= pmem_rdata;
          end
          r_dcache_resp <= 1'b1;
        end
      end
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign icache_rdata = r_icache_rdata;
  assign dcache_rdata = r_dcache_rdata;
  assign icache_resp  = r_icache_resp;
  assign dcache_resp  = r_dcache_resp;
  assign o_dbg_state  = r_state;

endmodule
